sid_filter_sched: RTL and testbench
===================================

Name: sid_filter_sched

Overview:
- Time-multiplexes one shared SID filter core across NCH SID channels (left/right SID in dual-SID builds).
- On each sample tick, runs one filter pass per channel in order 0..NCH-1 and snapshots that channel's filter registers for the whole pass, so CPU writes cannot tear a computation.
- Latches per-channel results, publishes them together, and flags overruns and core timeouts.
- Sits between the SID register files and the filter core; the mixer consumes its outputs.

Parameters:
- NCH, 2, number of channels sharing the core (1..4).
- RATE, 1, tick pulses per sample period (1..255).
- TIMEOUT, 31, max clk cycles waiting for core_done per pass (≥16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- tick  in  1  1 MHz clock-enable pulse, one clk wide.
- cfg  in  NCH*32  per channel {Mode_Vol,Res_Filt,Fc_hi,Fc_lo}; channel k occupies [32k+31:32k].
- core_start  out  1  one-cycle pass start to the core.
- core_ch  out  2  channel index of the current pass.
- core_cfg  out  32  snapshot of cfg for core_ch, stable from core_start until completion or abort.
- core_done  in  1  one-cycle pass-complete pulse from the core.
- core_sound  in  18  core result, valid with core_done.
- sound  out  NCH*18  last completed result per channel.
- sound_valid  out  1  one-cycle pulse after the last channel of a period is published.
- overrun  out  1  sticky: a sample period began while a schedule was still running.
- timeout  out  1  sticky: a pass was aborted for lack of core_done.
- err_clr  in  1  clears overrun and timeout.

Behaviour:
- Reset values (rst_n=0 at a clk edge): all outputs 0; state IDLE; tick counter 0; pending 0. Reset mid-pass abandons the pass; a late core_done after reset is ignored.
- Period: counter increments on tick and wraps at RATE-1. The wrap tick sets pending.
- If pending is already set, or state≠IDLE when the wrap tick arrives, set overrun and keep a single pending. Periods are never queued deeper than one.
- States:
  - IDLE: if pending, clear it, set ch=0, go LOAD.
  - LOAD: core_cfg <= cfg[ch]; core_ch <= ch; go START.
  - START: core_start=1 for exactly this cycle; clear wait counter; go WAIT.
  - WAIT: on core_done, latch sound[ch] <= core_sound and go NEXT. Else the wait counter increments; at TIMEOUT, set timeout, keep the old sound[ch], go NEXT.
  - NEXT: if ch==NCH-1, pulse sound_valid and go IDLE; else ch+1 and go LOAD.
- Latency: the wrap tick (cycle T) gives core_start at T+3 at the earliest. With core_done D cycles after start, sound_valid falls at T+3+NCH*(D+3)-2 (D=12, NCH=2: T+31).
- core_done outside WAIT is ignored. core_done in the same cycle as the timeout limit counts as done, with no timeout flag.
- err_clr takes priority over clearing but not over setting: if a set event and err_clr coincide, the flag ends set.
- cfg changes are visible only at the next LOAD of that channel.
- tick and wrap are processed in every state, including while a pass is in flight.
- Widths: sound slices pass through unmodified; no arithmetic on the data path.

Decomposition:
- Shared package sid_pkg holds:
  - SID_SOUND_W=18, SID_CFG_W=32;
  - field offsets FC_LO=0, FC_HI=8, RES_FILT=16, MODE_VOL=24;
  - state encoding IDLE/LOAD/START/WAIT/NEXT.
- One sub-module, sid_tick_div: the RATE divider with pending/overrun detect. The FSM stays in sid_filter_sched.

Test Plan:
- NCH=2, RATE=1, core model answers 12 cycles after start with 0x0ABCD (ch0) and 0x15432 (ch1), tick at cycle 10 -> core_start at 13 and 28. Then sound = {0x15432,0x0ABCD}, sound_valid pulse at cycle 41, no flags.
- cfg[0] changed from 0x1F40F800 to 0x0F10FFFF one cycle after ch0 LOAD -> core_cfg holds 0x1F40F800 through ch0 completion. The next period's ch0 LOAD shows 0x0F10FFFF.
- Model never asserts core_done for ch1, TIMEOUT=31 -> timeout=1 and ch1 sound keeps its previous value. sound_valid still pulses; the next period runs normally.
- RATE=1, core latency 40 cycles, ticks every 32 clks -> overrun=1 on the second tick. Only one extra period is run per backlog. err_clr then drops overrun to 0.
- rst_n low during WAIT of ch0, with core_done arriving 2 cycles after release -> outputs 0, state IDLE, and the stray core_done changes nothing.
- RATE=4 -> exactly one schedule per 4 ticks; a 16-tick run gives 4 sound_valid pulses.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared widths, cfg field offsets and scheduler state encoding for the SID filter path.
package sid_pkg;
   localparam int SID_SOUND_W = 18;
   localparam int SID_CFG_W   = 32;

   localparam int FC_LO    = 0;
   localparam int FC_HI    = 8;
   localparam int RES_FILT = 16;
   localparam int MODE_VOL = 24;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      NEXT  = 3'd4
   } sid_state_t;
endpackage

// File: rtl/sid_tick_div.sv
// Sample-period divider with a one-deep pending request; pending/overrun update one cycle after the wrap tick.
// No backpressure: a wrap while pending or busy folds into the sticky overrun flag.
module sid_tick_div #(
   parameter int RATE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_take,
   input  logic i_busy,
   input  logic i_err_clr,
   output logic o_pending,
   output logic o_overrun
);
   localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_pending;
   logic          r_overrun;
   logic          w_wrap;

   assign w_wrap = i_tick && (r_cnt == CW'(RATE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_wrap) r_pending <= 1'b1;
         else if (i_take) r_pending <= 1'b0;
         // a set event wins over a coincident clear
         if (w_wrap && (r_pending || i_busy)) r_overrun <= 1'b1;
         else if (i_err_clr) r_overrun <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_overrun = r_overrun;
endmodule

// File: rtl/sid_filter_sched.sv
// Time-multiplexes one SID filter core over NCH channels, one snapshot-protected pass per channel per period.
// Latency: core_start 3 cycles after the wrap tick; the core itself is never stalled, missing done aborts after TIMEOUT.
module sid_filter_sched
   import sid_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int RATE    = 1,
   parameter int TIMEOUT = 31
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tick,
   input  logic [NCH*SID_CFG_W-1:0]   cfg,
   output logic                       core_start,
   output logic [1:0]                 core_ch,
   output logic [SID_CFG_W-1:0]       core_cfg,
   input  logic                       core_done,
   input  logic [SID_SOUND_W-1:0]     core_sound,
   output logic [NCH*SID_SOUND_W-1:0] sound,
   output logic                       sound_valid,
   output logic                       overrun,
   output logic                       timeout,
   input  logic                       err_clr
);
   localparam int WW = $clog2(TIMEOUT + 1);

   sid_state_t r_state, w_state_nxt;
   logic [1:0]                 r_ch;
   logic [1:0]                 r_core_ch;
   logic [WW-1:0]              r_wait;
   logic [SID_CFG_W-1:0]       r_cfg;
   logic [NCH*SID_SOUND_W-1:0] r_sound;
   logic                       r_timeout;
   logic w_pending, w_take, w_start, w_svld, w_tmo_set, w_tmo_hit, w_last;

   assign w_last    = (r_ch == 2'(NCH - 1));
   assign w_tmo_hit = (r_wait == WW'(TIMEOUT - 1));

   sid_tick_div #(.RATE(RATE)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_tick    (tick),
      .i_take    (w_take),
      .i_busy    (r_state != IDLE),
      .i_err_clr (err_clr),
      .o_pending (w_pending),
      .o_overrun (overrun)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pending) w_state_nxt = LOAD;
         LOAD:    w_state_nxt = START;
         START:   w_state_nxt = WAIT;
         WAIT:    if (core_done || w_tmo_hit) w_state_nxt = NEXT;
         NEXT:    w_state_nxt = w_last ? IDLE : LOAD;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_take    = 1'b0;
      w_start   = 1'b0;
      w_svld    = 1'b0;
      w_tmo_set = 1'b0;
      case (r_state)
         IDLE:    w_take    = w_pending;
         START:   w_start   = 1'b1;
         WAIT:    w_tmo_set = !core_done && w_tmo_hit;
         NEXT:    w_svld    = w_last;
         default: ;
      endcase
   end

   // the cfg snapshot is taken only in LOAD so CPU writes cannot tear a pass
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ch      <= '0;
         r_core_ch <= '0;
         r_wait    <= '0;
         r_cfg     <= '0;
         r_sound   <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE:  r_ch <= '0;
            LOAD: begin
               r_cfg     <= cfg[r_ch*SID_CFG_W +: SID_CFG_W];
               r_core_ch <= r_ch;
            end
            START: r_wait <= '0;
            WAIT: begin
               if (core_done) r_sound[r_ch*SID_SOUND_W +: SID_SOUND_W] <= core_sound;
               else if (!w_tmo_hit) r_wait <= r_wait + 1'b1;
            end
            NEXT:  if (!w_last) r_ch <= r_ch + 2'd1;
            default: ;
         endcase
         if (w_tmo_set) r_timeout <= 1'b1;
         else if (err_clr) r_timeout <= 1'b0;
      end
   end

   assign core_start  = w_start;
   assign core_ch     = r_core_ch;
   assign core_cfg    = r_cfg;
   assign sound       = r_sound;
   assign sound_valid = w_svld;
   assign timeout     = r_timeout;
endmodule

// File: tb/tb_sid_filter_sched.sv
// Bench for sid_filter_sched: vector table on a RATE=1 instance, hand sequences on a RATE=4 instance.
module tb_sid_filter_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, want %h", nm, c, act, exp);
      end
   endtask

   // instance A: NCH=2 RATE=1 TIMEOUT=31, core latency 12
   logic        a_rst_n = 1'b0, a_tick = 1'b0, a_clr = 1'b0, a_inj = 1'b0;
   logic [63:0] a_cfg = '0;
   logic        a_start, a_svld, a_ovr, a_tmo, a_done;
   logic [1:0]  a_ch;
   logic [31:0] a_ccfg;
   logic [35:0] a_snd;
   logic        a_mdone = 1'b0, a_drop = 1'b0;
   logic [17:0] a_csnd = '0, a_v0 = '0, a_v1 = '0;
   int          a_rem = 0;

   assign a_done = a_mdone | a_inj;

   sid_filter_sched #(.NCH(2), .RATE(1), .TIMEOUT(31)) u_a (
      .clk(clk), .rst_n(a_rst_n), .tick(a_tick), .cfg(a_cfg),
      .core_start(a_start), .core_ch(a_ch), .core_cfg(a_ccfg),
      .core_done(a_done), .core_sound(a_csnd),
      .sound(a_snd), .sound_valid(a_svld), .overrun(a_ovr), .timeout(a_tmo),
      .err_clr(a_clr)
   );

   always @(negedge clk) begin
      a_mdone = 1'b0;
      if (!a_rst_n) a_rem = 0;
      else begin
         if (a_rem > 0) begin
            a_rem--;
            if (a_rem == 0 && !(a_drop && a_ch == 2'd1)) begin
               a_mdone = 1'b1;
               a_csnd  = (a_ch == 2'd0) ? a_v0 : a_v1;
            end
         end
         if (a_start) a_rem = 12;
      end
   end

   // instance B: NCH=2 RATE=4 TIMEOUT=63, core latency 40
   logic        b_rst_n = 1'b0, b_tick = 1'b0, b_clr = 1'b0;
   logic [63:0] b_cfg = {32'h22222222, 32'h11111111};
   logic        b_start, b_svld, b_ovr, b_tmo;
   logic [1:0]  b_ch;
   logic [31:0] b_ccfg;
   logic [35:0] b_snd;
   logic        b_done = 1'b0;
   logic [17:0] b_csnd = '0;
   int          b_rem = 0, b_nsv = 0, b_nst = 0;

   sid_filter_sched #(.NCH(2), .RATE(4), .TIMEOUT(63)) u_b (
      .clk(clk), .rst_n(b_rst_n), .tick(b_tick), .cfg(b_cfg),
      .core_start(b_start), .core_ch(b_ch), .core_cfg(b_ccfg),
      .core_done(b_done), .core_sound(b_csnd),
      .sound(b_snd), .sound_valid(b_svld), .overrun(b_ovr), .timeout(b_tmo),
      .err_clr(b_clr)
   );

   always @(negedge clk) begin
      b_done = 1'b0;
      if (!b_rst_n) b_rem = 0;
      else begin
         if (b_rem > 0) begin
            b_rem--;
            if (b_rem == 0) begin
               b_done = 1'b1;
               b_csnd = (b_ch == 2'd0) ? 18'h00001 : 18'h00002;
            end
         end
         if (b_start) b_rem = 40;
         if (b_svld) b_nsv++;
         if (b_start) b_nst++;
      end
   end

   localparam int K_DRV = 0, K_CFG = 1, K_MDL = 2, K_CTL = 3, K_CCF = 4, K_SND = 5;

   typedef struct {
      int          cyc;
      int          kind;
      logic        rst, tick, clr, inj;
      logic [63:0] cfg;
      logic        drop;
      logic [17:0] v0, v1;
      logic        e_start, e_svld, e_ovr, e_tmo;
      logic [1:0]  e_ch;
      logic [31:0] e_ccfg;
      logic [35:0] e_snd;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t blank(int c, int k);
      vec_t v;
      v = '{default: 0};
      v.cyc  = c;
      v.kind = k;
      return v;
   endfunction

   function automatic void drv(int c, logic r, logic t, logic cl, logic inj);
      vec_t v = blank(c, K_DRV);
      v.rst = r; v.tick = t; v.clr = cl; v.inj = inj;
      tab.push_back(v);
   endfunction

   function automatic void setcfg(int c, logic [63:0] cf);
      vec_t v = blank(c, K_CFG);
      v.cfg = cf;
      tab.push_back(v);
   endfunction

   function automatic void mdl(int c, logic d, logic [17:0] x0, logic [17:0] x1);
      vec_t v = blank(c, K_MDL);
      v.drop = d; v.v0 = x0; v.v1 = x1;
      tab.push_back(v);
   endfunction

   function automatic void ctl(int c, logic st, logic sv, logic ov, logic tm);
      vec_t v = blank(c, K_CTL);
      v.e_start = st; v.e_svld = sv; v.e_ovr = ov; v.e_tmo = tm;
      tab.push_back(v);
   endfunction

   function automatic void ccf(int c, logic [1:0] ch, logic [31:0] cf);
      vec_t v = blank(c, K_CCF);
      v.e_ch = ch; v.e_ccfg = cf;
      tab.push_back(v);
   endfunction

   function automatic void snd(int c, logic [35:0] s);
      vec_t v = blank(c, K_SND);
      v.e_snd = s;
      tab.push_back(v);
   endfunction

   task automatic b_pulse(input int gap);
      @(negedge clk) b_tick = 1'b1;
      @(negedge clk) b_tick = 1'b0;
      repeat (gap - 2) @(negedge clk);
   endtask

   initial begin
      vec_t v;
      int   sv0, st0;

      // cycle numbers are the clk edge at which the value is sampled
      drv(1, 0, 0, 0, 0);
      setcfg(1, {32'h0000A5A5, 32'h1F40F800});
      mdl(1, 0, 18'h0ABCD, 18'h15432);
      ctl(3, 0, 0, 0, 0); ccf(3, 0, 0); snd(3, 0);
      drv(4, 1, 0, 0, 0);
      drv(10, 1, 1, 0, 0);
      ctl(12, 0, 0, 0, 0);
      ctl(13, 1, 0, 0, 0); ccf(13, 0, 32'h1F40F800);
      setcfg(13, {32'h0000A5A5, 32'h0F10FFFF});
      ctl(14, 0, 0, 0, 0);
      ccf(25, 0, 32'h1F40F800); snd(25, 0);
      snd(26, {18'h0, 18'h0ABCD});
      ctl(28, 1, 0, 0, 0); ccf(28, 1, 32'h0000A5A5);
      ctl(40, 0, 0, 0, 0);
      ctl(41, 0, 1, 0, 0); snd(41, {18'h15432, 18'h0ABCD});
      ctl(42, 0, 0, 0, 0);
      // period 2: ch1 never answers
      mdl(42, 1, 18'h01111, 18'h15432);
      drv(50, 1, 1, 0, 0);
      ctl(53, 1, 0, 0, 0); ccf(53, 0, 32'h0F10FFFF);
      snd(66, {18'h15432, 18'h01111});
      ctl(68, 1, 0, 0, 0); ccf(68, 1, 32'h0000A5A5);
      ctl(99, 0, 0, 0, 0);
      ctl(100, 0, 1, 0, 1); snd(100, {18'h15432, 18'h01111});
      ctl(101, 0, 0, 0, 1);
      mdl(101, 0, 18'h02222, 18'h03333);
      drv(110, 1, 1, 0, 0);
      ctl(113, 1, 0, 0, 1);
      ctl(141, 0, 1, 0, 1); snd(141, {18'h03333, 18'h02222});
      drv(142, 1, 0, 1, 0);
      ctl(143, 0, 0, 0, 0);
      // overrun: second wrap mid-schedule, coinciding with err_clr
      drv(150, 1, 1, 0, 0);
      drv(155, 1, 1, 1, 0);
      ctl(156, 0, 0, 1, 0);
      ctl(181, 0, 1, 1, 0);
      ctl(183, 0, 0, 1, 0);
      ctl(184, 1, 0, 1, 0); ccf(184, 0, 32'h0F10FFFF);
      ctl(212, 0, 1, 1, 0);
      drv(213, 1, 0, 1, 0);
      ctl(214, 0, 0, 0, 0);
      // reset during ch0 WAIT, stray done after release
      drv(220, 1, 1, 0, 0);
      ctl(223, 1, 0, 0, 0);
      drv(226, 0, 0, 0, 0);
      ctl(227, 0, 0, 0, 0); ccf(227, 0, 0); snd(227, 0);
      drv(228, 1, 0, 0, 0);
      drv(230, 1, 0, 0, 1);
      ctl(231, 0, 0, 0, 0); snd(231, 0);
      ctl(240, 0, 0, 0, 0); ccf(240, 0, 0); snd(240, 0);

      for (int i = 0; i < tab.size(); i++) begin
         v = tab[i];
         while (cyc + 1 < v.cyc) begin
            @(negedge clk);
            a_tick = 1'b0;
            a_clr  = 1'b0;
            a_inj  = 1'b0;
         end
         case (v.kind)
            K_DRV: begin
               a_rst_n = v.rst; a_tick = v.tick; a_clr = v.clr; a_inj = v.inj;
            end
            K_CFG: a_cfg = v.cfg;
            K_MDL: begin
               a_drop = v.drop; a_v0 = v.v0; a_v1 = v.v1;
            end
            K_CTL: begin
               chk("core_start", v.cyc, 64'(a_start), 64'(v.e_start));
               chk("sound_valid", v.cyc, 64'(a_svld), 64'(v.e_svld));
               chk("overrun", v.cyc, 64'(a_ovr), 64'(v.e_ovr));
               chk("timeout", v.cyc, 64'(a_tmo), 64'(v.e_tmo));
            end
            K_CCF: begin
               chk("core_ch", v.cyc, 64'(a_ch), 64'(v.e_ch));
               chk("core_cfg", v.cyc, 64'(a_ccfg), 64'(v.e_ccfg));
            end
            K_SND: chk("sound", v.cyc, 64'(a_snd), 64'(v.e_snd));
            default: ;
         endcase
      end

      // instance B: one schedule per 4 ticks
      @(negedge clk) b_rst_n = 1'b1;
      repeat (3) @(negedge clk);
      sv0 = b_nsv;
      st0 = b_nst;
      for (int i = 0; i < 16; i++) begin
         b_pulse(24);
         if (i == 2) chk("b_rate_no_wrap_yet", cyc, 64'(b_nst - st0), 64'd0);
      end
      repeat (100) @(negedge clk);
      chk("b_rate_svld_count", cyc, 64'(b_nsv - sv0), 64'd4);
      chk("b_rate_start_count", cyc, 64'(b_nst - st0), 64'd8);
      chk("b_rate_overrun", cyc, 64'(b_ovr), 64'd0);
      chk("b_rate_sound", cyc, 64'(b_snd), 64'({18'h00002, 18'h00001}));

      // instance B: wraps every 32 clks against an 87-cycle schedule
      sv0 = b_nsv;
      st0 = b_nst;
      for (int i = 0; i < 12; i++) begin
         b_pulse(8);
         if (i == 3) chk("b_ovr_after_wrap1", cyc, 64'(b_ovr), 64'd0);
         if (i == 7) chk("b_ovr_after_wrap2", cyc, 64'(b_ovr), 64'd1);
      end
      repeat (200) @(negedge clk);
      chk("b_backlog_svld_count", cyc, 64'(b_nsv - sv0), 64'd2);
      chk("b_backlog_start_count", cyc, 64'(b_nst - st0), 64'd4);
      chk("b_ovr_sticky", cyc, 64'(b_ovr), 64'd1);
      chk("b_tmo_none", cyc, 64'(b_tmo), 64'd0);
      chk("b_core_cfg_last", cyc, 64'(b_ccfg), 64'h22222222);
      @(negedge clk) b_clr = 1'b1;
      @(negedge clk) b_clr = 1'b0;
      @(negedge clk);
      chk("b_ovr_cleared", cyc, 64'(b_ovr), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
